// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter that lets two requesters read bursts of words from a
// shared combinational 8x4 ROM.
module rom_burst_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [2:0] start_adr0,
   input  logic [2:0] start_adr1,
   input  logic [2:0] len0,
   input  logic [2:0] len1,
   output logic       gnt0,
   output logic       gnt1,
   output logic [2:0] rom_adr,
   input  logic [3:0] rom_data,
   output logic [3:0] rdata,
   output logic       rvalid,
   output logic       rid,
   output logic       done,
   output logic [6:0] burst_sum,
   output logic       busy
);

   typedef enum logic {IDLE, READ} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] addr;
   logic [2:0] count;
   logic [6:0] sum;
   logic       owner;
   logic       last_gnt;
   logic       any_req;
   logic       win;
   logic       load;
   logic       step;
   logic       last;

   // last_gnt resets to 1 so that requester 0 wins the first contention
   always_comb begin
      any_req = req0 | req1;
      win     = req1 & (~req0 | ~last_gnt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = READ;
         READ:    if (count == 3'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load = 1'b0;
      step = 1'b0;
      last = 1'b0;
      busy = 1'b0;
      case (state)
         IDLE: load = any_req;
         READ: begin
            step = 1'b1;
            last = (count == 3'd0);
            busy = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= 3'd0;
         count     <= 3'd0;
         sum       <= 7'd0;
         owner     <= 1'b0;
         last_gnt  <= 1'b1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         rdata     <= 4'd0;
         rvalid    <= 1'b0;
         rid       <= 1'b0;
         done      <= 1'b0;
         burst_sum <= 7'd0;
      end else begin
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         rvalid <= 1'b0;
         done   <= 1'b0;
         if (load) begin
            addr     <= win ? start_adr1 : start_adr0;
            count    <= win ? len1 : len0;
            sum      <= 7'd0;
            owner    <= win;
            last_gnt <= win;
            gnt0     <= ~win;
            gnt1     <= win;
         end
         if (step) begin
            rdata  <= rom_data;
            rvalid <= 1'b1;
            rid    <= owner;
            sum    <= sum + {3'b000, rom_data};
            addr   <= addr + 3'd1;
            count  <= count - 3'd1;
            if (last) begin
               done      <= 1'b1;
               burst_sum <= sum + {3'b000, rom_data};
            end
         end
      end
   end

   assign rom_adr = addr;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: directed scenarios plus random requests, checked
// every cycle against a burst-level queue model of the arbiter.
module tb_rom_burst_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [2:0] start_adr0 = 3'd0;
   logic [2:0] start_adr1 = 3'd0;
   logic [2:0] len0 = 3'd0;
   logic [2:0] len1 = 3'd0;
   logic       gnt0;
   logic       gnt1;
   logic [2:0] rom_adr;
   logic [3:0] rom_data;
   logic [3:0] rdata;
   logic       rvalid;
   logic       rid;
   logic       done;
   logic [6:0] burst_sum;
   logic       busy;

   int checks = 0;
   int errors = 0;

   rom_burst_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1),
      .start_adr0(start_adr0), .start_adr1(start_adr1),
      .len0(len0), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rom_adr(rom_adr), .rom_data(rom_data),
      .rdata(rdata), .rvalid(rvalid), .rid(rid),
      .done(done), .burst_sum(burst_sum), .busy(busy)
   );

   always #5 clk = ~clk;

   // ROM contents: each word is its address plus one
   assign rom_data = {1'b0, rom_adr} + 4'd1;

   typedef struct {
      logic [3:0] data;
      logic       id;
      logic       last;
      logic [6:0] sum;
   } word_t;

   word_t      pend[$];
   logic       lastWin   = 1'b1;
   logic       expGnt0   = 1'b0;
   logic       expGnt1   = 1'b0;
   logic       expRvalid = 1'b0;
   logic       expDone   = 1'b0;
   logic       expRid    = 1'b0;
   logic       expBusy   = 1'b0;
   logic [3:0] expRdata  = 4'd0;
   logic [6:0] expSum    = 7'd0;
   logic [2:0] expAdr    = 3'd0;

   // Burst-level model: a grant enqueues the whole burst, every later edge
   // delivers one queued word until the queue is empty again
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend.delete();
         lastWin   = 1'b1;
         expGnt0   = 1'b0;
         expGnt1   = 1'b0;
         expRvalid = 1'b0;
         expDone   = 1'b0;
         expRid    = 1'b0;
         expBusy   = 1'b0;
         expRdata  = 4'd0;
         expSum    = 7'd0;
         expAdr    = 3'd0;
      end else begin
         expGnt0   = 1'b0;
         expGnt1   = 1'b0;
         expRvalid = 1'b0;
         expDone   = 1'b0;
         if (pend.size() > 0) begin
            word_t w;
            w = pend.pop_front();
            expRvalid = 1'b1;
            expRdata  = w.data;
            expRid    = w.id;
            expAdr    = expAdr + 3'd1;
            if (w.last) begin
               expDone = 1'b1;
               expSum  = w.sum;
            end
         end else if (req0 || req1) begin
            logic       who;
            int         st;
            int         ln;
            int         acc;
            who = (req0 && req1) ? !lastWin : req1;
            st  = who ? int'(start_adr1) : int'(start_adr0);
            ln  = who ? int'(len1) : int'(len0);
            acc = 0;
            for (int i = 0; i <= ln; i++) begin
               word_t w;
               w.data = 4'(((st + i) % 8) + 1);
               acc    = acc + int'(w.data);
               w.id   = who;
               w.last = (i == ln);
               w.sum  = 7'(acc);
               pend.push_back(w);
            end
            expAdr  = 3'(st);
            lastWin = who;
            expGnt0 = !who;
            expGnt1 = who;
         end
         expBusy = (pend.size() > 0);
      end
   end

   int         wordsSeen = 0;
   int         doneCount = 0;
   logic [6:0] doneSums[$];
   logic       doneIds[$];

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("gnt0", int'(gnt0), int'(expGnt0));
      checkOutput("gnt1", int'(gnt1), int'(expGnt1));
      checkOutput("rvalid", int'(rvalid), int'(expRvalid));
      checkOutput("done", int'(done), int'(expDone));
      checkOutput("busy", int'(busy), int'(expBusy));
      checkOutput("rid", int'(rid), int'(expRid));
      checkOutput("rdata", int'(rdata), int'(expRdata));
      checkOutput("burst_sum", int'(burst_sum), int'(expSum));
      checkOutput("rom_adr", int'(rom_adr), int'(expAdr));
   endtask

   // One cycle: check at the falling edge, then update requesters
   task automatic applyStimulus(input bit randomReq);
      @(negedge clk);
      checkAll();
      if (rvalid) wordsSeen++;
      if (done) begin
         doneCount++;
         doneSums.push_back(burst_sum);
         doneIds.push_back(rid);
      end
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (randomReq) begin
         if (!req0 && $urandom_range(0, 3) == 0) begin
            req0       = 1'b1;
            start_adr0 = 3'($urandom_range(0, 7));
            len0       = 3'($urandom_range(0, 7));
         end
         if (!req1 && $urandom_range(0, 3) == 0) begin
            req1       = 1'b1;
            start_adr1 = 3'($urandom_range(0, 7));
            len1       = 3'($urandom_range(0, 7));
         end
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      repeat (2) applyStimulus(1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      repeat (2) applyStimulus(1'b0);
      checkOutput("resetBusy", int'(busy), 0);
      rst_n = 1'b1;

      // single burst with address wrap
      doneSums.delete(); doneIds.delete();
      req0 = 1'b1; start_adr0 = 3'd6; len0 = 3'd2;
      repeat (6) applyStimulus(1'b0);
      checkOutput("cnt030", doneSums.size(), 1);
      if (doneSums.size() == 1) begin
         checkOutput("sum030", int'(doneSums[0]), 16);
         checkOutput("id030", int'(doneIds[0]), 0);
      end

      // full-length burst from requester 1
      doneSums.delete(); doneIds.delete();
      req1 = 1'b1; start_adr1 = 3'd3; len1 = 3'd7;
      repeat (11) applyStimulus(1'b0);
      checkOutput("cnt031", doneSums.size(), 1);
      if (doneSums.size() == 1) begin
         checkOutput("sum031", int'(doneSums[0]), 36);
         checkOutput("id031", int'(doneIds[0]), 1);
      end

      // single-word burst
      doneSums.delete(); doneIds.delete();
      req0 = 1'b1; start_adr0 = 3'd7; len0 = 3'd0;
      repeat (4) applyStimulus(1'b0);
      checkOutput("cnt033", doneSums.size(), 1);
      if (doneSums.size() == 1) checkOutput("sum033", int'(doneSums[0]), 8);

      // contention right after reset, twice
      doReset();
      doneSums.delete(); doneIds.delete();
      for (int r = 0; r < 2; r++) begin
         req0 = 1'b1; start_adr0 = 3'd0; len0 = 3'd0;
         req1 = 1'b1; start_adr1 = 3'd5; len1 = 3'd0;
         repeat (6) applyStimulus(1'b0);
      end
      checkOutput("cnt032", doneSums.size(), 4);
      if (doneSums.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            checkOutput("id032", int'(doneIds[k]), k % 2);
            checkOutput("sum032", int'(doneSums[k]), (k % 2 == 0) ? 1 : 6);
         end
      end

      // requester drops its request after the grant
      base = wordsSeen;
      doneSums.delete();
      req0 = 1'b1; start_adr0 = 3'd2; len0 = 3'd3;
      repeat (7) applyStimulus(1'b0);
      checkOutput("words035", wordsSeen - base, 4);
      checkOutput("cnt035", doneSums.size(), 1);

      // reset in the middle of a burst
      base = wordsSeen;
      doneSums.delete(); doneIds.delete();
      req0 = 1'b1; start_adr0 = 3'd0; len0 = 3'd7;
      for (int c = 0; c < 20 && (wordsSeen - base) < 3; c++) applyStimulus(1'b0);
      checkOutput("words034", wordsSeen - base, 3);
      rst_n = 1'b0;
      #1;
      checkOutput("rst034rvalid", int'(rvalid), 0);
      checkOutput("rst034adr", int'(rom_adr), 0);
      checkOutput("rst034rdata", int'(rdata), 0);
      checkOutput("rst034busy", int'(busy), 0);
      checkOutput("rst034done", doneSums.size(), 0);
      repeat (2) applyStimulus(1'b0);
      rst_n = 1'b1;
      req1 = 1'b1; start_adr1 = 3'd4; len1 = 3'd1;
      repeat (5) applyStimulus(1'b0);
      checkOutput("cnt034", doneIds.size(), 1);
      if (doneIds.size() == 1) checkOutput("id034", int'(doneIds[0]), 1);

      // random traffic, then drain
      doneSums.delete(); doneIds.delete();
      repeat (2000) applyStimulus(1'b1);
      repeat (30) applyStimulus(1'b0);
      checkOutput("drainBusy", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
